// File: rtl/code_pkg.sv
// Shared definitions for the code stepper: code width, debounce state encoding
// and the modulo-32 step helper used by the code register.
package code_pkg;

    localparam int CODE_W = 5;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } deb_state_t;

    // One advance of the code; the natural wrap of a CODE_W-bit add/subtract
    // gives 31 -> 0 going up and 0 -> 31 going down.
    function automatic logic [CODE_W-1:0] next_code(input logic [CODE_W-1:0] code,
                                                    input logic              up);
        return up ? code + CODE_W'(1) : code - CODE_W'(1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer followed by a four-state
// debounce FSM that emits exactly one step pulse per accepted press.
module btn_debounce
    import code_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
)
(
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_step,
    output logic o_busy
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync_meta;
    logic             r_sync;
    deb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    deb_state_t       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Bring the raw button into the clock domain before anything looks at it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the old
            // values, so this really is a two-stage shift and not one wire.
            r_sync_meta <= i_btn;
            r_sync      <= r_sync_meta;
        end
    end

    // FSM state and sample counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic. r_cnt counts consecutive qualifying samples; the
    // sample seen in IDLE is the first high of the press window.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a value unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_step      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_sync) begin
                    w_state_nxt = WAIT_PRESS;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            WAIT_PRESS: begin
                if (!r_sync) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= CNT_LAST) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                o_step      = 1'b1;
                w_state_nxt = WAIT_RELEASE;
                w_cnt_nxt   = '0;
            end
            WAIT_RELEASE: begin
                if (r_sync) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt >= CNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_busy = (r_state != IDLE);

endmodule

// File: rtl/code_stepper.sv
// 5-bit code stepper for a 7-segment display: advances on a debounced button
// press or on auto-run prescaler ticks, with a synchronous load override.
module code_stepper
    import code_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int AUTO_DIV        = 50000000
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              step_btn,
    input  logic              dir,
    input  logic              load,
    input  logic [CODE_W-1:0] load_val,
    input  logic              auto_en,
    output logic              c1,
    output logic              c2,
    output logic              c3,
    output logic              c4,
    output logic              c5,
    output logic              busy
);

    localparam int               PRE_W    = $clog2(AUTO_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(AUTO_DIV - 1);

    logic [PRE_W-1:0]  r_pre;
    logic [CODE_W-1:0] r_code;
    logic              w_step;
    logic              w_tick;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (step_btn),
        .o_step (w_step),
        .o_busy (busy)
    );

    assign w_tick = auto_en && (r_pre == PRE_LAST);

    // Prescaler: held at 0 while auto-run is off so the first tick always
    // lands a full AUTO_DIV cycles after auto_en rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
        end else if (!auto_en || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // Code register: load wins outright; a step and a tick in the same cycle
    // collapse into a single advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code <= '0;
        end else if (load) begin
            r_code <= load_val;
        end else if (w_step || w_tick) begin
            r_code <= next_code(r_code, dir);
        end
    end

    assign c1 = r_code[4];
    assign c2 = r_code[3];
    assign c3 = r_code[2];
    assign c4 = r_code[1];
    assign c5 = r_code[0];

endmodule

// File: tb/tb_code_stepper.sv
// Self-checking bench for code_stepper with DEBOUNCE_CYCLES=4, AUTO_DIV=8.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_code_stepper;

    localparam int DC = 4;
    localparam int AD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       step_btn = 1'b0;
    logic       dir = 1'b1;
    logic       load = 1'b0;
    logic [4:0] load_val = '0;
    logic       auto_en = 1'b0;
    logic       c1, c2, c3, c4, c5, busy;

    int n_vec = 0;
    int n_err = 0;
    int model_code = 0;

    code_stepper #(
        .DEBOUNCE_CYCLES (DC),
        .AUTO_DIV        (AD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .step_btn (step_btn),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .auto_en  (auto_en),
        .c1       (c1),
        .c2       (c2),
        .c3       (c3),
        .c4       (c4),
        .c5       (c5),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] code_now();
        return {c1, c2, c3, c4, c5};
    endfunction

    function automatic int wrap32(input int v);
        return ((v % 32) + 32) % 32;
    endfunction

    // Stimulus helpers (no checking here).
    task automatic load_code(input int v);
        @(negedge clk);
        load     = 1'b1;
        load_val = 5'(v);
        @(negedge clk);
        load       = 1'b0;
        model_code = v;
    endtask

    task automatic press(input int hold, input logic d);
        @(negedge clk);
        dir      = d;
        step_btn = 1'b1;
        repeat (hold) @(negedge clk);
        step_btn = 1'b0;
        repeat (12) @(negedge clk);
        model_code = wrap32(model_code + (d ? 1 : -1));
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_vec++;
        if (code_now() !== 5'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_initial: code=%b busy=%b expected code=00000 busy=0", code_now(), busy);
        end
        rst = 1'b0;
        load_code(13);
        n_vec++;
        if (code_now() !== 5'd13) begin
            n_err++;
            $display("FAIL reset_load13: code=%0d expected 13", code_now());
        end
        @(negedge clk);
        step_btn = 1'b1;
        repeat (4) @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_busy_before: busy=%b expected 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (code_now() !== 5'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: code=%b busy=%b expected code=00000 busy=0", code_now(), busy);
        end
        step_btn = 1'b0;
        @(negedge clk);
        rst        = 1'b0;
        model_code = 0;
        repeat (10) @(negedge clk);
        n_vec++;
        if (code_now() !== 5'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_after: code=%0d busy=%b expected code=0 busy=0", code_now(), busy);
        end
    endtask

    task automatic test_debounced_step;
        int exp;
        load_code(5);
        @(negedge clk); dir = 1'b1; step_btn = 1'b1;
        @(negedge clk); step_btn = 1'b0;
        @(negedge clk); step_btn = 1'b1;
        @(negedge clk); step_btn = 1'b0;
        @(negedge clk); step_btn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            exp = (i >= 2 + DC + 1) ? 6 : 5;
            n_vec++;
            if (code_now() !== 5'(exp)) begin
                n_err++;
                $display("FAIL step_latency cyc=%0d: code=%0d expected %0d", i, code_now(), exp);
            end
            if (i == 10) begin
                n_vec++;
                if (busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL step_busy_held: busy=%b expected 1", busy);
                end
            end
        end
        step_btn = 1'b0;
        repeat (12) @(negedge clk);
        model_code = 6;
        n_vec++;
        if (code_now() !== 5'd6 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL step_single: code=%0d busy=%b expected code=6 busy=0", code_now(), busy);
        end
    endtask

    task automatic test_wrap;
        load_code(31);
        press(10, 1'b1);
        n_vec++;
        if (code_now() !== 5'(model_code) || model_code != 0) begin
            n_err++;
            $display("FAIL wrap_up: code=%0d expected 0", code_now());
        end
        load_code(0);
        press(10, 1'b0);
        n_vec++;
        if (code_now() !== 5'(model_code) || model_code != 31) begin
            n_err++;
            $display("FAIL wrap_down: code=%0d expected 31", code_now());
        end
    endtask

    task automatic test_auto_run;
        load_code(0);
        @(negedge clk);
        dir     = 1'b1;
        auto_en = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            n_vec++;
            if (code_now() !== 5'(i / AD)) begin
                n_err++;
                $display("FAIL auto_run cyc=%0d: code=%0d expected %0d", i, code_now(), i / AD);
            end
        end
        auto_en    = 1'b0;
        model_code = 40 / AD;
        repeat (20) @(negedge clk);
        n_vec++;
        if (code_now() !== 5'(model_code)) begin
            n_err++;
            $display("FAIL auto_frozen: code=%0d expected %0d", code_now(), model_code);
        end
    endtask

    // Lines up a tick and a step pulse on the same clock edge, optionally
    // with a load of 17 on that edge too.
    task automatic coincide(input logic with_load, input int exp, input string tag);
        load_code(10);
        @(negedge clk);
        dir     = 1'b1;
        auto_en = 1'b1;
        @(negedge clk);
        step_btn = 1'b1;
        repeat (6) @(negedge clk);
        n_vec++;
        if (code_now() !== 5'd10) begin
            n_err++;
            $display("FAIL %s_before: code=%0d expected 10", tag, code_now());
        end
        if (with_load) begin
            load     = 1'b1;
            load_val = 5'd17;
        end
        @(negedge clk);
        load    = 1'b0;
        auto_en = 1'b0;
        n_vec++;
        if (code_now() !== 5'(exp)) begin
            n_err++;
            $display("FAIL %s_edge: code=%0d expected %0d", tag, code_now(), exp);
        end
        step_btn = 1'b0;
        repeat (12) @(negedge clk);
        model_code = exp;
        n_vec++;
        if (code_now() !== 5'(exp)) begin
            n_err++;
            $display("FAIL %s_settled: code=%0d expected %0d", tag, code_now(), exp);
        end
    endtask

    task automatic test_priority;
        coincide(1'b1, 17, "prio_load");
        coincide(1'b0, 11, "prio_step_tick");
    endtask

    task automatic test_reset_mid_debounce;
        load_code(20);
        @(negedge clk);
        dir      = 1'b1;
        step_btn = 1'b1;
        repeat (4) @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL middeb_busy: busy=%b expected 1", busy);
        end
        rst      = 1'b1;
        step_btn = 1'b0;
        @(negedge clk);
        rst        = 1'b0;
        model_code = 0;
        repeat (15) @(negedge clk);
        n_vec++;
        if (code_now() !== 5'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL middeb_discard: code=%0d busy=%b expected code=0 busy=0", code_now(), busy);
        end
        // Button held straight through a reset pulse counts as a fresh press.
        @(negedge clk);
        step_btn = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        n_vec++;
        if (code_now() !== 5'd1) begin
            n_err++;
            $display("FAIL held_through_reset: code=%0d expected 1", code_now());
        end
        step_btn = 1'b0;
        repeat (12) @(negedge clk);
        model_code = 1;
        n_vec++;
        if (code_now() !== 5'd1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL held_through_reset_release: code=%0d busy=%b expected code=1 busy=0", code_now(), busy);
        end
    endtask

    task automatic test_random;
        int   op;
        int   n;
        logic d;
        for (int k = 0; k < 12; k++) begin
            op = int'($urandom_range(0, 2));
            case (op)
                0: load_code(int'($urandom_range(0, 31)));
                1: begin
                    // dir wiggles during the press; only its value on the
                    // pulse cycle (7th edge after the raw rise) may count.
                    @(negedge clk);
                    dir      = 1'($urandom_range(0, 1));
                    step_btn = 1'b1;
                    for (int i = 1; i <= 5; i++) begin
                        @(negedge clk);
                        dir = 1'($urandom_range(0, 1));
                    end
                    @(negedge clk);
                    d   = 1'($urandom_range(0, 1));
                    dir = d;
                    @(negedge clk);
                    dir = ~d;
                    repeat (3) @(negedge clk);
                    step_btn = 1'b0;
                    repeat (12) @(negedge clk);
                    model_code = wrap32(model_code + (d ? 1 : -1));
                end
                default: begin
                    n = int'($urandom_range(0, 30));
                    d = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    dir     = d;
                    auto_en = 1'b1;
                    repeat (n) @(negedge clk);
                    auto_en    = 1'b0;
                    model_code = wrap32(model_code + (n / AD) * (d ? 1 : -1));
                    @(negedge clk);
                end
            endcase
            n_vec++;
            if (code_now() !== 5'(model_code)) begin
                n_err++;
                $display("FAIL random op%0d iter=%0d: code=%0d expected %0d", op, k, code_now(), model_code);
            end
        end
    endtask

    initial begin
        test_reset;
        test_debounced_step;
        test_wrap;
        test_auto_run;
        test_priority;
        test_reset_mid_debounce;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/code_stepper.md
CODE_STEPPER -- requirements
Module: code_stepper

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples required to accept a button level change.
REQ-002 Parameter AUTO_DIV, default 50000000: clock cycles per auto-advance tick; legal range is 2 or more.
REQ-003 clk  input  1  single clock; every register updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 step_btn  input  1  raw, asynchronous, bouncing push-button; high = pressed.
REQ-006 dir  input  1  1 = count up, 0 = count down; sampled on the cycle an advance is applied.
REQ-007 load  input  1  synchronous load strobe.
REQ-008 load_val  input  5  value taken on load; bit 4 maps to c1, bit 0 maps to c5.
REQ-009 auto_en  input  1  1 = free-run advance on prescaler ticks.
REQ-010 c1..c5  output  1 each  registered 5-bit code to the 7-segment decoder; c1 = MSB, c5 = LSB.
REQ-011 busy  output  1  high while the debouncer is not in IDLE.

Function
REQ-012 step_btn shall pass through a 2-flop synchronizer before any other use.
REQ-013 The debounce FSM shall have four states: IDLE, WAIT_PRESS, PRESSED and WAIT_RELEASE.
- IDLE: moves to WAIT_PRESS on a synchronized high.
- WAIT_PRESS: returns to IDLE on any low sample; moves to PRESSED after DEBOUNCE_CYCLES consecutive highs.
- PRESSED: lasts exactly one cycle and emits a one-cycle step pulse; moves to WAIT_RELEASE.
- WAIT_RELEASE: returns to IDLE after DEBOUNCE_CYCLES consecutive lows; any high sample restarts the low count.
REQ-014 A sustained press shall produce exactly one step pulse, with no auto-repeat.
REQ-015 The prescaler shall count 0..AUTO_DIV-1 while auto_en=1 and shall emit a one-cycle tick when it wraps.
REQ-016 The prescaler shall be held at 0 while auto_en=0, so the first tick comes AUTO_DIV cycles after auto_en rises.
REQ-017 Advance priority shall be: load, then the step pulse or tick.
- load=1: code <= load_val, and any step or tick in that cycle is discarded.
- Step and tick in the same cycle: exactly one advance.
REQ-018 Each advance shall add 1 (dir=1) or subtract 1 (dir=0) modulo 32, so 31 wraps to 0 going up and 0 wraps to 31 going down.
REQ-019 The code register shall drive c1..c5 directly, with no combinational path from any input to c1..c5.
REQ-020 Latency shall be:
- load: code visible on c1..c5 one cycle after load is sampled.
- step: code visible 2 (synchronizer) + DEBOUNCE_CYCLES + 1 cycles after the raw edge, for a bounce-free press.
REQ-021 A toggle of dir mid-press shall only affect the advance applied on the cycle of the step pulse.

Reset
REQ-022 Asserting rst shall immediately force:
- code to 0, so c1..c5 are all 0;
- the debounce FSM to IDLE and busy to 0;
- the debounce counter, prescaler and synchronizer flops to 0.
REQ-023 If the button is held through reset release, the block shall debounce it as a new press and produce one step after release of rst.
REQ-024 Reset asserted mid-debounce shall discard the pending step.

Structure
REQ-025 A shared package code_pkg shall hold CODE_W=5 and the debounce state enum (IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE).
REQ-026 The synchronizer and debounce FSM shall live in one sub-module, btn_debounce, which outputs the step pulse and busy.
REQ-027 The prescaler and code register shall stay in code_stepper.

Verification (bench parameters: DEBOUNCE_CYCLES=4, AUTO_DIV=8)
REQ-028 Reset: assert rst mid-run with code=13 -> c1..c5=00000 and busy=0 immediately, before any clock edge.
REQ-029 Debounced step: raw button bounces 1,0,1,0, then holds high 20 cycles, dir=1, code=5 -> exactly one advance to 6, appearing 7 cycles after the stable high starts.
REQ-030 Wrap-around, both directions:
- code=31, dir=1, one press -> 0.
- code=0, dir=0, one press -> 31.
REQ-031 Auto-run: auto_en=1, dir=1, code=0 for 40 cycles -> code advances every 8 cycles and reads 5 at cycle 40.
- auto_en dropped -> code frozen.
REQ-032 Priority, with code=10, dir=1:
- load=1, load_val=17 in the same cycle as a tick and a step pulse -> 17, not 18.
- Tick and step pulse coincident, no load -> 11.
REQ-033 Reset mid-debounce: rst pulsed while in WAIT_PRESS -> no advance; busy returns to 0.
